// File: rtl/id_queue_pkg.sv
// Shared decode constants, operand-select enums and the decode bundle
// exchanged between the instruction decoder and the queue/issue stage.
package id_queue_pkg;

  // Major opcodes
  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;
  localparam logic [6:0] INST_FENCE    = 7'b0001111;
  localparam logic [6:0] INST_CSR      = 7'b1110011;
  // The load-use interlock keys off this alias
  localparam logic [6:0] OPC_LOAD      = INST_TYPE_L;

  // funct3 values that need special legality handling
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSR_RSV = 3'b100;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Operand source selects produced by the control half of the decoder
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_UIMM} op1_sel_e;
  typedef enum logic [2:0] {OP2_ZERO, OP2_RS2, OP2_IMM_I, OP2_IMM_S, OP2_FOUR, OP2_UIMM} op2_sel_e;
  typedef enum logic [1:0] {JB_ZERO, JB_PC, JB_RS1} jb_sel_e;
  typedef enum logic [2:0] {JO_ZERO, JO_IMM_B, JO_IMM_J, JO_IMM_I, JO_FOUR} jo_sel_e;

  // Decode bundle of the head entry, captured into the output slot on pop
  typedef struct packed {
    logic        rd_wen;
    logic [4:0]  rd_waddr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] jump_base;
    logic [31:0] jump_offs;
    logic        illegal;
    logic        is_load;
  } dec_out_t;

endpackage

// File: rtl/id_queue_dec.sv
// Purely combinational decode of one instruction. Register read addresses
// depend only on the instruction word; operands additionally mux in the
// register-file data, so the address path never loops through read data.
module id_dec
  import id_queue_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [31:0] i_inst,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_reg1_rdata,
  input  logic [31:0] i_reg2_rdata,
  output logic [4:0]  o_reg1_raddr,
  output logic [4:0]  o_reg2_raddr,
  output dec_out_t    o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;

  logic        w_legal;
  logic        w_rd_wen;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_is_load;
  op1_sel_e    w_op1_sel;
  op2_sel_e    w_op2_sel;
  jb_sel_e     w_jb_sel;
  jo_sel_e     w_jo_sel;

  assign w_opcode = i_inst[6:0];
  assign w_rd     = i_inst[11:7];
  assign w_funct3 = i_inst[14:12];
  assign w_rs1    = i_inst[19:15];
  assign w_rs2    = i_inst[24:20];
  assign w_funct7 = i_inst[31:25];

  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};

  // Control decode: legality, register usage and operand sources.
  // Every field is only set on a legal path, so an illegal word falls out
  // with no reads, no writeback and all operand selects at zero.
  always_comb begin
    w_legal   = 1'b0;
    w_rd_wen  = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_is_load = 1'b0;
    w_op1_sel = OP1_ZERO;
    w_op2_sel = OP2_ZERO;
    w_jb_sel  = JB_ZERO;
    w_jo_sel  = JO_ZERO;
    case (w_opcode)
      INST_TYPE_I: begin
        if ((w_funct3 == F3_SLL) ? (w_funct7 == F7_BASE) :
            (w_funct3 == F3_SR)  ? (w_funct7 == F7_BASE || w_funct7 == F7_ALT) : 1'b1) begin
          w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM_I;
        end
      end
      INST_TYPE_R_M: begin
        if (w_funct7 == F7_BASE ||
            (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SR))) begin
          w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1;
          w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2;
        end else if (w_funct7 == F7_MULDIV && EN_M != 0) begin
          w_legal = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2;
          // MUL* write back directly; DIV/REM are multi-cycle in execute,
          // which writes back later and resumes at pc+4
          if (!w_funct3[2]) begin
            w_rd_wen = 1'b1;
          end else begin
            w_jb_sel = JB_PC; w_jo_sel = JO_FOUR;
          end
        end
      end
      INST_TYPE_L: begin
        if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
          w_is_load = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM_I;
        end
      end
      INST_TYPE_S: begin
        if (w_funct3 inside {3'b000, 3'b001, 3'b010}) begin
          w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM_S;
        end
      end
      INST_TYPE_B: begin
        if (!(w_funct3 inside {3'b010, 3'b011})) begin
          w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2;
          w_jb_sel = JB_PC; w_jo_sel = JO_IMM_B;
        end
      end
      INST_JAL: begin
        w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1;
        w_op1_sel = OP1_PC; w_op2_sel = OP2_FOUR;
        w_jb_sel = JB_PC; w_jo_sel = JO_IMM_J;
      end
      INST_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
          w_op1_sel = OP1_PC; w_op2_sel = OP2_FOUR;
          w_jb_sel = JB_RS1; w_jo_sel = JO_IMM_I;
        end
      end
      INST_LUI: begin
        w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1;
        w_op1_sel = OP1_UIMM;
      end
      INST_AUIPC: begin
        w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1;
        w_op1_sel = OP1_PC; w_op2_sel = OP2_UIMM;
      end
      INST_FENCE: begin
        if (w_funct3 inside {3'b000, 3'b001}) begin
          w_legal = 1'b1; w_jb_sel = JB_PC; w_jo_sel = JO_FOUR;
        end
      end
      INST_CSR: begin
        if (w_funct3 == F3_PRIV) begin
          w_legal = 1'b1;
        end else if (w_funct3 != F3_CSR_RSV) begin
          // Immediate CSR forms (funct3[2]=1) carry zimm in rs1, not a register
          w_legal = 1'b1; w_rd_wen = 1'b1; w_use_rd = 1'b1;
          w_use_rs1 = !w_funct3[2];
        end
      end
      default: ;
    endcase
  end

  assign o_reg1_raddr = w_use_rs1 ? w_rs1 : 5'd0;
  assign o_reg2_raddr = w_use_rs2 ? w_rs2 : 5'd0;

  // Datapath: resolve the selects against immediates, pc and read data
  always_comb begin
    o_dec          = '0;
    o_dec.rd_wen   = w_rd_wen;
    o_dec.rd_waddr = w_use_rd ? w_rd : 5'd0;
    o_dec.illegal  = !w_legal;
    o_dec.is_load  = w_is_load;
    case (w_op1_sel)
      OP1_RS1:  o_dec.op1 = i_reg1_rdata;
      OP1_PC:   o_dec.op1 = i_inst_addr;
      OP1_UIMM: o_dec.op1 = w_imm_u;
      default:  o_dec.op1 = 32'd0;
    endcase
    case (w_op2_sel)
      OP2_RS2:   o_dec.op2 = i_reg2_rdata;
      OP2_IMM_I: o_dec.op2 = w_imm_i;
      OP2_IMM_S: o_dec.op2 = w_imm_s;
      OP2_FOUR:  o_dec.op2 = 32'd4;
      OP2_UIMM:  o_dec.op2 = w_imm_u;
      default:   o_dec.op2 = 32'd0;
    endcase
    case (w_jb_sel)
      JB_PC:   o_dec.jump_base = i_inst_addr;
      JB_RS1:  o_dec.jump_base = i_reg1_rdata;
      default: o_dec.jump_base = 32'd0;
    endcase
    case (w_jo_sel)
      JO_IMM_B: o_dec.jump_offs = w_imm_b;
      JO_IMM_J: o_dec.jump_offs = w_imm_j;
      JO_IMM_I: o_dec.jump_offs = w_imm_i;
      JO_FOUR:  o_dec.jump_offs = 32'd4;
      default:  o_dec.jump_offs = 32'd0;
    endcase
  end

endmodule

// File: rtl/id_queue.sv
// Buffered decode stage: a FIFO of fetched instructions, decode of the head
// entry, a load-use interlock and a registered output slot toward execute.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Fetch side: inst_valid_i/inst_ready_o, where ready depends only on
// reset and queue fullness. Execute side: valid_o/ready_i, and valid_o plus
// all slot contents stay stable while valid_o=1 and ready_i=0. flush_i
// overrides both sides for that cycle.
module id_queue
  import id_queue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int EN_M       = 1,
  parameter int EN_HAZARD  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        flush_i,
  output logic [4:0]  reg1_raddr_o,
  output logic [4:0]  reg2_raddr_o,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [31:0] jump_base_addr_o,
  output logic [31:0] jump_offs_addr_o,
  output logic [31:0] reg1_rdata_o,
  output logic [31:0] reg2_rdata_o,
  output logic        rd_wen_o,
  output logic [4:0]  rd_waddr_o,
  output logic        illegal_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

  // Queue storage and pointers (extra MSB tells full from empty)
  logic [31:0]    r_inst_mem [FIFO_DEPTH];
  logic [31:0]    r_addr_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;

  // Output slot
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_jump_base;
  logic [31:0] r_jump_offs;
  logic [31:0] r_reg1_rdata;
  logic [31:0] r_reg2_rdata;
  logic        r_rd_wen;
  logic [4:0]  r_rd_waddr;
  logic        r_illegal;
  logic        r_is_load;

  logic [PTR_W:0] w_count;
  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_free;
  logic           w_hazard;
  logic [31:0]    w_head_inst;
  logic [31:0]    w_head_addr;
  logic [4:0]     w_reg1_raddr;
  logic [4:0]     w_reg2_raddr;
  dec_out_t       w_dec;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_CNT);

  assign inst_ready_o = rst_n & !w_full;
  assign w_push       = inst_valid_i & inst_ready_o & !flush_i;
  assign w_free       = !r_valid | ready_i;

  // An empty queue presents an all-zero word: it decodes as illegal with no
  // register reads, so the read ports sit at x0 and no hazard can fire.
  assign w_head_inst = w_empty ? 32'd0 : r_inst_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_addr = w_empty ? 32'd0 : r_addr_mem[r_rd_ptr[PTR_W-1:0]];

  id_dec #(
    .EN_M (EN_M)
  ) u_dec (
    .i_inst       (w_head_inst),
    .i_inst_addr  (w_head_addr),
    .i_reg1_rdata (reg1_rdata_i),
    .i_reg2_rdata (reg2_rdata_i),
    .o_reg1_raddr (w_reg1_raddr),
    .o_reg2_raddr (w_reg2_raddr),
    .o_dec        (w_dec)
  );

  assign reg1_raddr_o = w_reg1_raddr;
  assign reg2_raddr_o = w_reg2_raddr;

  // Load result is not available until the load leaves execute, so a head
  // instruction reading the slot's load destination waits one cycle. Unused
  // read ports are already x0, and rd=x0 is excluded explicitly.
  assign w_hazard = (EN_HAZARD != 0) && r_valid && r_is_load && (r_rd_waddr != 5'd0) &&
                    ((w_reg1_raddr == r_rd_waddr) || (w_reg2_raddr == r_rd_waddr));

  assign w_pop = !w_empty & w_free & !w_hazard & !flush_i;

  // Queue storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr[PTR_W-1:0]] <= inst_i;
      r_addr_mem[r_wr_ptr[PTR_W-1:0]] <= inst_addr_i;
    end
  end

  // Queue pointers: flush empties, otherwise advance on push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Output slot: load on pop, drain when free and nothing pops, else hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_jump_base  <= '0;
      r_jump_offs  <= '0;
      r_reg1_rdata <= '0;
      r_reg2_rdata <= '0;
      r_rd_wen     <= 1'b0;
      r_rd_waddr   <= '0;
      r_illegal    <= 1'b0;
      r_is_load    <= 1'b0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (w_pop) begin
      r_valid      <= 1'b1;
      r_inst       <= w_head_inst;
      r_inst_addr  <= w_head_addr;
      r_op1        <= w_dec.op1;
      r_op2        <= w_dec.op2;
      r_jump_base  <= w_dec.jump_base;
      r_jump_offs  <= w_dec.jump_offs;
      r_reg1_rdata <= reg1_rdata_i;
      r_reg2_rdata <= reg2_rdata_i;
      r_rd_wen     <= w_dec.rd_wen;
      r_rd_waddr   <= w_dec.rd_waddr;
      r_illegal    <= w_dec.illegal;
      r_is_load    <= w_dec.is_load;
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o          = r_valid;
  assign inst_o           = r_inst;
  assign inst_addr_o      = r_inst_addr;
  assign op1_o            = r_op1;
  assign op2_o            = r_op2;
  assign jump_base_addr_o = r_jump_base;
  assign jump_offs_addr_o = r_jump_offs;
  assign reg1_rdata_o     = r_reg1_rdata;
  assign reg2_rdata_o     = r_reg2_rdata;
  assign rd_wen_o         = r_rd_wen;
  assign rd_waddr_o       = r_rd_waddr;
  assign illegal_o        = r_illegal;

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: reset, issue latency, back-pressure, load-use
// bubble, flush, M-extension legality and reset with a full queue.
module tb_id_queue;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        flush_i;
  logic        ready_i;

  // Instance with the M extension enabled
  logic        inst_ready_o, valid_o, rd_wen_o, illegal_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o, rd_waddr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, jump_base_addr_o, jump_offs_addr_o;
  logic [31:0] reg1_rdata_o, reg2_rdata_o;

  // Instance with the M extension disabled (same stimulus)
  logic        n_inst_ready_o, n_valid_o, n_rd_wen_o, n_illegal_o;
  logic [4:0]  n_reg1_raddr_o, n_reg2_raddr_o, n_rd_waddr_o;
  logic [31:0] n_reg1_rdata_i, n_reg2_rdata_i;
  logic [31:0] n_inst_o, n_inst_addr_o, n_op1_o, n_op2_o, n_jump_base_addr_o, n_jump_offs_addr_o;
  logic [31:0] n_reg1_rdata_o, n_reg2_rdata_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Register file model: x0 reads 0, xN reads 0x1000+N
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'h1000 + 32'(a));
  endfunction

  // addi xK, x0, K
  function automatic logic [31:0] addi_k(input int k);
    return {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
  endfunction

  assign reg1_rdata_i   = rf_val(reg1_raddr_o);
  assign reg2_rdata_i   = rf_val(reg2_raddr_o);
  assign n_reg1_rdata_i = rf_val(n_reg1_raddr_o);
  assign n_reg2_rdata_i = rf_val(n_reg2_raddr_o);

  id_queue #(.FIFO_DEPTH(4), .EN_M(1), .EN_HAZARD(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .flush_i(flush_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .jump_base_addr_o(jump_base_addr_o),
    .jump_offs_addr_o(jump_offs_addr_o), .reg1_rdata_o(reg1_rdata_o),
    .reg2_rdata_o(reg2_rdata_o), .rd_wen_o(rd_wen_o), .rd_waddr_o(rd_waddr_o),
    .illegal_o(illegal_o)
  );

  id_queue #(.FIFO_DEPTH(4), .EN_M(0), .EN_HAZARD(1)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .inst_ready_o(n_inst_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .flush_i(flush_i),
    .reg1_raddr_o(n_reg1_raddr_o), .reg2_raddr_o(n_reg2_raddr_o),
    .reg1_rdata_i(n_reg1_rdata_i), .reg2_rdata_i(n_reg2_rdata_i),
    .valid_o(n_valid_o), .ready_i(ready_i), .inst_o(n_inst_o), .inst_addr_o(n_inst_addr_o),
    .op1_o(n_op1_o), .op2_o(n_op2_o), .jump_base_addr_o(n_jump_base_addr_o),
    .jump_offs_addr_o(n_jump_offs_addr_o), .reg1_rdata_o(n_reg1_rdata_o),
    .reg2_rdata_o(n_reg2_rdata_o), .rd_wen_o(n_rd_wen_o), .rd_waddr_o(n_rd_waddr_o),
    .illegal_o(n_illegal_o)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance past an edge, push one word
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] a);
    inst_valid_i = 1'b1;
    inst_i       = w;
    inst_addr_i  = a;
    tick();
    inst_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", valid_o); end
    n_checks++; if (inst_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_inst_ready got %0b exp 0", inst_ready_o); end
    n_checks++; if (op2_o !== 32'd0) begin n_errors++; $display("FAIL reset_op2 got %h exp 0", op2_o); end
    n_checks++; if (rd_wen_o !== 1'b0) begin n_errors++; $display("FAIL reset_rd_wen got %0b exp 0", rd_wen_o); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (inst_ready_o !== 1'b1) begin n_errors++; $display("FAIL release_inst_ready got %0b exp 1", inst_ready_o); end
  endtask

  task automatic test_addi();
    ready_i = 1'b1;
    push(32'h00500093, 32'h0);
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL addi_latency got %0b exp 0", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL addi_valid got %0b exp 1", valid_o); end
    n_checks++; if (op2_o !== 32'd5) begin n_errors++; $display("FAIL addi_op2 got %h exp 5", op2_o); end
    n_checks++; if (op1_o !== 32'd0) begin n_errors++; $display("FAIL addi_op1 got %h exp 0", op1_o); end
    n_checks++; if (rd_waddr_o !== 5'd1) begin n_errors++; $display("FAIL addi_rd_waddr got %0d exp 1", rd_waddr_o); end
    n_checks++; if (rd_wen_o !== 1'b1) begin n_errors++; $display("FAIL addi_rd_wen got %0b exp 1", rd_wen_o); end
    n_checks++; if (inst_o !== 32'h00500093) begin n_errors++; $display("FAIL addi_inst got %h exp 00500093", inst_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL addi_drain got %0b exp 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    int got;
    ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      inst_valid_i = 1'b1;
      inst_i       = addi_k(k);
      inst_addr_i  = 32'h100 + 32'(4 * k);
      n_checks++; if (inst_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_ready_%0d got %0b exp 1", k, inst_ready_o); end
      exp_q.push_back(addi_k(k));
      tick();
    end
    inst_valid_i = 1'b0;
    n_checks++; if (inst_ready_o !== 1'b0) begin n_errors++; $display("FAIL full_ready got %0b exp 0", inst_ready_o); end
    tick(); tick(); tick();
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL held_valid got %0b exp 1", valid_o); end
    n_checks++; if (inst_o !== addi_k(1)) begin n_errors++; $display("FAIL held_inst got %h exp %h", inst_o, addi_k(1)); end
    // Offer a sixth word while popping: a full queue still refuses it
    inst_valid_i = 1'b1;
    inst_i       = addi_k(6);
    inst_addr_i  = 32'h118;
    ready_i      = 1'b1;
    #1;
    n_checks++; if (inst_ready_o !== 1'b0) begin n_errors++; $display("FAIL full_pop_ready got %0b exp 0", inst_ready_o); end
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (valid_o === 1'b1) begin
        got++;
        if (exp_q.size() > 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          n_checks++; if (inst_o !== e) begin n_errors++; $display("FAIL order_%0d got %h exp %h", got, inst_o, e); end
        end else begin
          n_checks++; n_errors++; $display("FAIL extra_issue got %h exp none", inst_o);
        end
      end
      tick();
      inst_valid_i = 1'b0;
    end
    n_checks++; if (got !== 5) begin n_errors++; $display("FAIL issue_count got %0d exp 5", got); end
    exp_q.delete();
  endtask

  task automatic test_hazard();
    ready_i = 1'b1;
    // lw x2,0(x1) then add x3,x2,x2: one bubble
    push(32'h0000A103, 32'h200);
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL hz_pre got %0b exp 0", valid_o); end
    push(32'h002101B3, 32'h204);
    n_checks++; if (valid_o !== 1'b1 || inst_o !== 32'h0000A103) begin n_errors++; $display("FAIL hz_lw got %0b/%h exp 1/0000a103", valid_o, inst_o); end
    n_checks++; if (op1_o !== 32'h1001 || rd_waddr_o !== 5'd2) begin n_errors++; $display("FAIL hz_lw_dec got %h/%0d exp 1001/2", op1_o, rd_waddr_o); end
    n_checks++; if (reg1_raddr_o !== 5'd2) begin n_errors++; $display("FAIL hz_head_raddr got %0d exp 2", reg1_raddr_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL hz_bubble got %0b exp 0", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1 || inst_o !== 32'h002101B3) begin n_errors++; $display("FAIL hz_add got %0b/%h exp 1/002101b3", valid_o, inst_o); end
    n_checks++; if (op1_o !== 32'h1002 || op2_o !== 32'h1002) begin n_errors++; $display("FAIL hz_add_ops got %h/%h exp 1002/1002", op1_o, op2_o); end
    tick();
    // lw x2,0(x1) then add x3,x1,x1: no bubble
    push(32'h0000A103, 32'h210);
    push(32'h001081B3, 32'h214);
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL nohz_lw got %0b exp 1", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1 || inst_o !== 32'h001081B3) begin n_errors++; $display("FAIL nohz_add got %0b/%h exp 1/001081b3", valid_o, inst_o); end
    tick();
    // lw x0,0(x1) then add x3,x0,x0: x0 never interlocks
    push(32'h0000A003, 32'h220);
    push(32'h000001B3, 32'h224);
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL x0_lw got %0b exp 1", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1 || inst_o !== 32'h000001B3) begin n_errors++; $display("FAIL x0_add got %0b/%h exp 1/000001b3", valid_o, inst_o); end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    ready_i = 1'b0;
    for (int k = 7; k <= 10; k++) push(addi_k(k), 32'h300 + 32'(4 * k));
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL flush_pre got %0b exp 1", valid_o); end
    flush_i      = 1'b1;
    inst_valid_i = 1'b1;
    inst_i       = addi_k(11);
    inst_addr_i  = 32'h33C;
    tick();
    flush_i      = 1'b0;
    inst_valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_valid got %0b exp 0", valid_o); end
    n_checks++; if (inst_ready_o !== 1'b1) begin n_errors++; $display("FAIL flush_ready got %0b exp 1", inst_ready_o); end
    ready_i = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (valid_o === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL flush_empty issued %0d exp 0", seen); end
  endtask

  task automatic test_m_ext();
    ready_i = 1'b1;
    push(32'h023100B3, 32'h400);
    tick();
    n_checks++; if (illegal_o !== 1'b0 || rd_wen_o !== 1'b1) begin n_errors++; $display("FAIL mul_m1 got ill=%0b wen=%0b exp 0/1", illegal_o, rd_wen_o); end
    n_checks++; if (op1_o !== 32'h1002 || op2_o !== 32'h1003) begin n_errors++; $display("FAIL mul_ops got %h/%h exp 1002/1003", op1_o, op2_o); end
    n_checks++; if (n_valid_o !== 1'b1 || n_illegal_o !== 1'b1 || n_rd_wen_o !== 1'b0) begin n_errors++; $display("FAIL mul_m0 got v=%0b ill=%0b wen=%0b exp 1/1/0", n_valid_o, n_illegal_o, n_rd_wen_o); end
    n_checks++; if (n_op1_o !== 32'd0 || n_op2_o !== 32'd0) begin n_errors++; $display("FAIL mul_m0_ops got %h/%h exp 0/0", n_op1_o, n_op2_o); end
    // div x1,x2,x3: no direct writeback, resume at pc+4
    push(32'h023140B3, 32'h404);
    tick();
    n_checks++; if (illegal_o !== 1'b0 || rd_wen_o !== 1'b0 || rd_waddr_o !== 5'd1) begin n_errors++; $display("FAIL div_ctrl got ill=%0b wen=%0b rd=%0d exp 0/0/1", illegal_o, rd_wen_o, rd_waddr_o); end
    n_checks++; if (jump_base_addr_o !== 32'h404 || jump_offs_addr_o !== 32'd4) begin n_errors++; $display("FAIL div_jump got %h/%h exp 404/4", jump_base_addr_o, jump_offs_addr_o); end
    tick();
  endtask

  task automatic test_decode();
    ready_i = 1'b1;
    push(32'h123450FF, 32'h500);
    tick();
    n_checks++; if (illegal_o !== 1'b1 || rd_wen_o !== 1'b0) begin n_errors++; $display("FAIL opc7f got ill=%0b wen=%0b exp 1/0", illegal_o, rd_wen_o); end
    n_checks++; if (op1_o !== 32'd0 || op2_o !== 32'd0 || jump_base_addr_o !== 32'd0 || jump_offs_addr_o !== 32'd0) begin n_errors++; $display("FAIL opc7f_ops got %h/%h/%h/%h exp 0", op1_o, op2_o, jump_base_addr_o, jump_offs_addr_o); end
    n_checks++; if (inst_o !== 32'h123450FF) begin n_errors++; $display("FAIL opc7f_inst got %h exp 123450ff", inst_o); end
    // sw x2,-4(x1)
    push(32'hFE20AE23, 32'h504);
    tick();
    n_checks++; if (op2_o !== 32'hFFFFFFFC || op1_o !== 32'h1001 || rd_wen_o !== 1'b0) begin n_errors++; $display("FAIL sw got op2=%h op1=%h wen=%0b exp fffffffc/1001/0", op2_o, op1_o, rd_wen_o); end
    // jal x1,+8
    push(32'h008000EF, 32'h508);
    tick();
    n_checks++; if (op1_o !== 32'h508 || op2_o !== 32'd4 || rd_waddr_o !== 5'd1) begin n_errors++; $display("FAIL jal_ops got %h/%h rd=%0d exp 508/4/1", op1_o, op2_o, rd_waddr_o); end
    n_checks++; if (jump_base_addr_o !== 32'h508 || jump_offs_addr_o !== 32'd8) begin n_errors++; $display("FAIL jal_jump got %h/%h exp 508/8", jump_base_addr_o, jump_offs_addr_o); end
    tick();
  endtask

  task automatic test_reset_full();
    int seen;
    ready_i = 1'b0;
    for (int k = 12; k <= 16; k++) push(addi_k(k), 32'h600 + 32'(4 * k));
    n_checks++; if (inst_ready_o !== 1'b0 || valid_o !== 1'b1) begin n_errors++; $display("FAIL rf_pre got rdy=%0b v=%0b exp 0/1", inst_ready_o, valid_o); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rf_valid got %0b exp 0", valid_o); end
    n_checks++; if (inst_ready_o !== 1'b0) begin n_errors++; $display("FAIL rf_ready_in_reset got %0b exp 0", inst_ready_o); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (inst_ready_o !== 1'b1) begin n_errors++; $display("FAIL rf_ready_after got %0b exp 1", inst_ready_o); end
    ready_i = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (valid_o === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL rf_empty issued %0d exp 0", seen); end
  endtask

  initial begin
    rst_n        = 1'b0;
    inst_valid_i = 1'b0;
    inst_i       = 32'd0;
    inst_addr_i  = 32'd0;
    flush_i      = 1'b0;
    ready_i      = 1'b0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_m_ext();
    test_decode();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
